// File: rtl/pipelined_adder_pkg.sv
// Shared ALU definitions: operation encoding for the add/sub select and
// default datapath geometry reused by other ALU units.
package pipelined_adder_pkg;
    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;
    localparam int   DEF_WIDTH = 16;
    localparam int   DEF_SEG   = 4;
endpackage

// File: rtl/pipelined_adder_seg_adder.sv
// Combinational SEG-bit ripple-carry segment built from full-adder cells;
// one instance resolves one pipeline stage's slice of the operands.
module FullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module seg_adder #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] A,
    input  logic [SEG-1:0] B,
    input  logic           Cin,
    output logic [SEG-1:0] Sum,
    output logic           Cout
);
    logic [SEG:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < SEG; i++) begin : g_fa
        FullAdder u_fa (
            .A   (A[i]),
            .B   (B[i]),
            .Cin (c[i]),
            .Sum (Sum[i]),
            .Cout(c[i+1])
        );
    end

    assign Cout = c[SEG];
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: one SEG-bit segment per stage, carry
// registered between stages, whole-pipeline stall on output back-pressure.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);
    localparam int STAGES = WIDTH / SEG;

    logic advance;

    assign in_ready = ~(out_valid & ~out_ready);
    assign advance  = in_ready;

    // Stage k sees the operand bits not yet consumed (skew) and the sum bits
    // already resolved (deskew); both shrink/grow by SEG bits per stage.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int RW = WIDTH - k * SEG;

        logic [RW-1:0]          a_i;
        logic [RW-1:0]          b_i;
        logic                   c_i;
        logic                   v_i;
        logic [(k+1)*SEG-1:0]   s_o;
        logic [SEG-1:0]         seg_sum;
        logic                   seg_co;

        if (k == 0) begin : g_src
            assign a_i = A;
            assign b_i = (Sub == OP_SUB) ? ~B : B;
            assign c_i = (Sub == OP_ADD) ? Cin : ~Cin;
            assign v_i = in_valid;
            assign s_o = seg_sum;
        end else begin : g_src
            assign a_i = stg[k-1].g_reg.a_r;
            assign b_i = stg[k-1].g_reg.b_r;
            assign c_i = stg[k-1].g_reg.c_r;
            assign v_i = stg[k-1].g_reg.v_r;
            assign s_o = {seg_sum, stg[k-1].g_reg.s_r};
        end

        seg_adder #(.SEG(SEG)) u_seg (
            .A   (a_i[SEG-1:0]),
            .B   (b_i[SEG-1:0]),
            .Cin (c_i),
            .Sum (seg_sum),
            .Cout(seg_co)
        );

        if (k < STAGES - 1) begin : g_reg
            logic [RW-SEG-1:0]    a_r;
            logic [RW-SEG-1:0]    b_r;
            logic [(k+1)*SEG-1:0] s_r;
            logic                 c_r;
            logic                 v_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r <= 1'b0;
                end else if (advance) begin
                    v_r <= v_i;
                end
                if (advance) begin
                    a_r <= a_i[RW-1:SEG];
                    b_r <= b_i[RW-1:SEG];
                    s_r <= s_o;
                    c_r <= seg_co;
                end
            end
        end else begin : g_out
            // The top segment holds the MSBs of A and Beff, so the overflow
            // test needs nothing beyond this stage's inputs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    Sum       <= '0;
                    Cout      <= 1'b0;
                    Ovf       <= 1'b0;
                    Zero      <= 1'b0;
                end else if (advance) begin
                    out_valid <= v_i;
                    if (v_i) begin
                        Sum  <= s_o;
                        Cout <= seg_co;
                        Ovf  <= (a_i[SEG-1] == b_i[SEG-1]) && (seg_sum[SEG-1] != a_i[SEG-1]);
                        Zero <= ~|s_o;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: directed corner cases, a stalled
// stream, mid-flight reset and randomized traffic with random back-pressure.
module tb_pipelined_adder;
    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;
    logic             Zero;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        int               acc;
        int               stl;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   s0 = 0;
    bit   rand_rdy = 1'b0;
    bit   stall_win = 1'b0;
    bit   held_v = 1'b0;
    logic [WIDTH+3:0] held;

    pipelined_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .Sub      (Sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Sum      (Sum),
        .Cout     (Cout),
        .Ovf      (Ovf),
        .Zero     (Zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.acc = 0; e.stl = 0;
        return e;
    endfunction

    // Reference: exact integer arithmetic, flags from the true results.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic ci, input logic s);
        int   r;
        int   sr;
        int   sa;
        int   sbv;
        exp_t e;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (s) begin
            r  = int'(a) - int'(b) - int'(ci);
            sr = sa - sbv - int'(ci);
        end else begin
            r  = int'(a) + int'(b) + int'(ci);
            sr = sa + sbv + int'(ci);
        end
        e.sum  = r[WIDTH-1:0];
        e.cout = s ? (r >= 0) : (r > 65535);
        e.ovf  = (sr > 32767) || (sr < -32768);
        e.zero = (e.sum == '0);
        e.acc  = 0;
        e.stl  = 0;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic s, input exp_t e);
        bit acc;
        bit ok;
        ok = 1'b0;
        A = a; B = b; Cin = ci; Sub = s; in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk); #1;
            ok = acc;
        end
        in_valid = 1'b0;
        chk("accept", 32'(ok), 32'd1);
        e.acc = cyc;
        e.stl = stall_cnt;
        sb.push_back(e);
    endtask

    task automatic send_rand();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic ci;
        logic s;
        a  = pick();
        b  = pick();
        ci = 1'($urandom_range(0, 1));
        s  = 1'($urandom_range(0, 1));
        send(a, b, ci, s, model(a, b, ci, s));
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy)
                out_ready = ($urandom_range(0, 3) != 0);
            else if (stall_win)
                out_ready = !(cyc >= s0 + 5 && cyc <= s0 + 7);
            else
                out_ready = 1'b1;
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v)
                    chk("hold_stable", {out_valid, Sum, Cout, Ovf, Zero}, held);
                held_v = 1'b0;
                if (out_valid && !out_ready) begin
                    held_v = 1'b1;
                    held   = {out_valid, Sum, Cout, Ovf, Zero};
                    stall_cnt++;
                    chk("in_ready_stall", in_ready, 0);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("spurious_valid", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("sum",  Sum,  e.sum);
                        chk("cout", Cout, e.cout);
                        chk("ovf",  Ovf,  e.ovf);
                        chk("zero", Zero, e.zero);
                        chk("latency", cyc - e.acc - (stall_cnt - e.stl), STAGES - 1);
                    end
                end
            end
        end
    end

    initial begin
        int st0;
        rst = 1'b1; in_valid = 1'b1; A = 16'hFFFF; B = 16'h0001; Cin = 1'b1; Sub = 1'b0;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_outputs", {Sum, Cout, Ovf, Zero}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", {out_valid, Sum, Cout, Ovf, Zero}, 0);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        send(16'h1234, 16'h0FFF, 1'b1, 1'b0, mk(16'h2234, 1'b0, 1'b0, 1'b0));
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
        send(16'h0003, 16'h0005, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
        drain();

        st0 = stall_cnt;
        s0 = cyc;
        stall_win = 1'b1;
        repeat (8) send_rand();
        drain();
        stall_win = 1'b0;
        chk("stall_cycles", stall_cnt - st0, 3);

        repeat (3) send_rand();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        repeat (6) begin
            @(negedge clk);
            chk("no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        send(16'h00F0, 16'h0F0F, 1'b0, 1'b0, mk(16'h0FFF, 1'b0, 1'b0, 1'b0));
        drain();

        rand_rdy = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end else begin
                send_rand();
            end
        end
        rand_rdy = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
